// File: rtl/serial_word_assembler_if.sv
// Bit-stream and word-output bundle for serial_word_assembler.
// Master drives framed bits; slave returns assembled words.
interface serial_word_assembler_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  Valid_SI;
  logic                  Start_SI;
  logic                  Bit_DI;
  logic                  Busy_SO;
  logic                  WrEn_SO;
  logic [DATA_WIDTH-1:0] Data_DO;
  logic                  FrameErr_SO;

  modport master (
    output Valid_SI,
    output Start_SI,
    output Bit_DI,
    input  Busy_SO,
    input  WrEn_SO,
    input  Data_DO,
    input  FrameErr_SO
  );

  modport slave (
    input  Valid_SI,
    input  Start_SI,
    input  Bit_DI,
    output Busy_SO,
    output WrEn_SO,
    output Data_DO,
    output FrameErr_SO
  );
endinterface

// File: rtl/serial_word_assembler.sv
// Framed serial-to-parallel word assembler with framing-error pulse.
// Words appear on Data_DO with a one-cycle WrEn_SO strobe.
module serial_word_assembler #(
  parameter int DATA_WIDTH = 6,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic                 Clk_CI,
  input logic                 Rst_RI,
  serial_word_assembler_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int DW = DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW-1:0]   sreg, sreg_n;
  logic [DW-1:0]   data, data_n;
  logic            wren, wren_n;
  logic            ferr, ferr_n;
  logic [DW-1:0]   shin;
  logic [DW-1:0]   first;

  // Shift direction places the first bit at MSB or LSB once full.
  always_comb begin
    if (MSB_FIRST) begin
      shin  = {sreg[DW-2:0], bus.Bit_DI};
      first = {{(DW-1){1'b0}}, bus.Bit_DI};
    end else begin
      shin  = {bus.Bit_DI, sreg[DW-1:1]};
      first = {bus.Bit_DI, {(DW-1){1'b0}}};
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    data_n  = data;
    wren_n  = 1'b0;
    ferr_n  = 1'b0;
    if (bus.Valid_SI) begin
      unique case (state)
        IDLE: begin
          if (bus.Start_SI) begin
            sreg_n  = first;
            cnt_n   = ONE;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.Start_SI) begin
            sreg_n = first;
            cnt_n  = ONE;
            ferr_n = 1'b1;
          end else if (cnt == LAST) begin
            sreg_n  = shin;
            data_n  = shin;
            wren_n  = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            sreg_n = shin;
            cnt_n  = cnt + ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      data  <= '0;
      wren  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sreg  <= sreg_n;
      data  <= data_n;
      wren  <= wren_n;
      ferr  <= ferr_n;
    end
  end

  assign bus.Busy_SO     = (state == SHIFT);
  assign bus.WrEn_SO     = wren;
  assign bus.Data_DO     = data;
  assign bus.FrameErr_SO = ferr;
endmodule

// File: tb/tb_serial_word_assembler.sv
// Scoreboard bench: MSB-first and LSB-first instances, shared stimulus.
// Frame-level model predicts words, pulses and busy.
module tb_serial_word_assembler;
  localparam int DW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_word_assembler_if #(.DATA_WIDTH(DW)) ia ();
  serial_word_assembler_if #(.DATA_WIDTH(DW)) ib ();

  serial_word_assembler #(
    .DATA_WIDTH(DW),
    .MSB_FIRST (1'b1)
  ) dut_msb (
    .Clk_CI(clk),
    .Rst_RI(rst),
    .bus   (ia)
  );

  serial_word_assembler #(
    .DATA_WIDTH(DW),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .Clk_CI(clk),
    .Rst_RI(rst),
    .bus   (ib)
  );

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            frame[$];
  bit            exp_busy = 0;
  bit            exp_wren = 0;
  bit            exp_ferr = 0;
  bit            exp_rst  = 0;
  logic [DW-1:0] hold0 = '0;
  logic [DW-1:0] hold1 = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t",
                  name, act, exp, $time);
  endtask

  // Frame-level model: a frame is the list of bits since Start.
  task automatic model_step(input bit r, input bit v,
                            input bit s, input bit b);
    logic [DW-1:0] w0, w1;
    exp_wren = 0;
    exp_ferr = 0;
    exp_rst  = 0;
    if (r) begin
      frame.delete();
      exp_rst = 1;
    end else if (v) begin
      if (s) begin
        if (frame.size() > 0) exp_ferr = 1;
        frame.delete();
        frame.push_back(b);
      end else if (frame.size() > 0) begin
        frame.push_back(b);
        if (frame.size() == DW) begin
          for (int k = 1; k <= DW; k++) begin
            w0[DW-k] = frame[k-1];
            w1[k-1]  = frame[k-1];
          end
          q0.push_back(w0);
          q1.push_back(w1);
          exp_wren = 1;
          frame.delete();
        end
      end
    end
    exp_busy = (frame.size() > 0);
  endtask

  task automatic drive(input bit r, input bit v,
                       input bit s, input bit b);
    rst = r;
    ia.Valid_SI = v; ia.Start_SI = s; ia.Bit_DI = b;
    ib.Valid_SI = v; ib.Start_SI = s; ib.Bit_DI = b;
    @(posedge clk);
    model_step(r, v, s, b);
    @(negedge clk);
  endtask

  task automatic send(input bit s, input bit b);
    drive(1'b0, 1'b1, s, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) send(i == DW - 1, w[i]);
  endtask

  always @(negedge clk) begin
    chk("busy_msb", ia.Busy_SO, exp_busy);
    chk("busy_lsb", ib.Busy_SO, exp_busy);
    chk("wren_msb", ia.WrEn_SO, exp_wren);
    chk("wren_lsb", ib.WrEn_SO, exp_wren);
    chk("ferr_msb", ia.FrameErr_SO, exp_ferr);
    chk("ferr_lsb", ib.FrameErr_SO, exp_ferr);
    if (exp_rst) begin
      hold0 = '0;
      hold1 = '0;
    end
    if (ia.WrEn_SO && q0.size() > 0) hold0 = q0.pop_front();
    if (ib.WrEn_SO && q1.size() > 0) hold1 = q1.pop_front();
    chk("data_msb", ia.Data_DO, hold0);
    chk("data_lsb", ib.Data_DO, hold1);
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_data", ia.Data_DO, 0);

    // 1,0,1,1,0,0 with a 3-cycle Valid gap after bit 3
    send(1, 1); send(0, 0); send(0, 1);
    idle(3);
    send(0, 1); send(0, 0); send(0, 0);
    chk("kat_msb_2c", ia.Data_DO, 6'h2C);
    chk("kat_lsb_0d", ib.Data_DO, 6'h0D);
    chk("kat_wren", ia.WrEn_SO, 1);
    idle(2);

    send_word(6'h3F);
    chk("b2b_first", ia.Data_DO, 6'h3F);
    send_word(6'h15);
    chk("b2b_second", ia.Data_DO, 6'h15);
    idle(1);

    send(1, 1); send(0, 1); send(0, 1);
    send(1, 1);
    chk("ferr_pulse", ia.FrameErr_SO, 1);
    chk("ferr_hold", ia.Data_DO, 6'h15);
    for (int i = 0; i < 5; i++) send(0, 1);
    chk("ferr_new", ia.Data_DO, 6'h3F);

    for (int i = 0; i < 10; i++) send(0, i[0]);
    chk("garbage_busy", ia.Busy_SO, 0);
    chk("garbage_hold", ia.Data_DO, 6'h3F);

    send(1, 0); send(0, 1); send(0, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("midrst_data", ia.Data_DO, 0);
    chk("midrst_busy", ia.Busy_SO, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(0, 1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      bit r, v, s, b;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0);
      b = $urandom_range(0, 1);
      drive(r, v, s, b);
    end
    idle(2);

    chk("q_msb_empty", q0.size(), 0);
    chk("q_lsb_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
